// File: rtl/music_pkg.sv
// Shared note codes, sequencer states and the song table
// used by the melody sequencer and its timer.
package music_pkg;

  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_C    = 3'd1;
  localparam logic [2:0] NOTE_D    = 3'd2;
  localparam logic [2:0] NOTE_E    = 3'd3;
  localparam logic [2:0] NOTE_F    = 3'd4;
  localparam logic [2:0] NOTE_G    = 3'd5;
  localparam logic [2:0] NOTE_A    = 3'd6;
  localparam logic [2:0] NOTE_B    = 3'd7;

  localparam int MAX_SONG = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [2:0] note;
    logic [1:0] dur;
  } step_t;

  // dur is beats-1, so the default song spans 13 beats
  function automatic step_t song_at(input logic [3:0] idx);
    step_t s;
    case (idx)
      4'd0:    s = '{NOTE_C,    2'd0};
      4'd1:    s = '{NOTE_D,    2'd0};
      4'd2:    s = '{NOTE_E,    2'd0};
      4'd3:    s = '{NOTE_F,    2'd0};
      4'd4:    s = '{NOTE_G,    2'd1};
      4'd5:    s = '{NOTE_A,    2'd1};
      4'd6:    s = '{NOTE_REST, 2'd0};
      4'd7:    s = '{NOTE_B,    2'd3};
      default: s = '{NOTE_REST, 2'd0};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; stops at zero and never wraps.
// zero flags the final cycle of a loaded interval.
module seq_timer #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the song table, driving note code and gate
// with a silent articulation gap at the end of every step.
module melody_sequencer #(
  parameter int TICKS_PER_MS = 20000,
  parameter int BEAT_MS      = 250,
  parameter int GAP_MS       = 20,
  parameter int SONG_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic [2:0] note,
  output logic       gate,
  output logic       busy,
  output logic [3:0] step_idx,
  output logic       done
);

  import music_pkg::*;

  localparam int TW = $clog2(4*BEAT_MS*TICKS_PER_MS);
  localparam logic [TW-1:0] GAP_LOAD =
    TW'(GAP_MS*TICKS_PER_MS - 1);
  localparam logic [3:0] LAST = 4'(SONG_LEN - 1);

  function automatic logic [TW-1:0] play_load(
    input logic [1:0] d
  );
    int p;
    p = ((int'(d) + 1)*BEAT_MS - GAP_MS)*TICKS_PER_MS - 1;
    return TW'(p);
  endfunction

  state_t        state, state_n;
  logic [2:0]    note_n;
  logic          gate_n, busy_n, done_n;
  logic [3:0]    step_n, nxt_idx;
  logic          go, tload, tzero;
  logic [TW-1:0] tval;
  step_t         ent;

  seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tload),
    .load_val (tval),
    .zero     (tzero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      note     <= NOTE_REST;
      gate     <= 1'b0;
      busy     <= 1'b0;
      step_idx <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      note     <= note_n;
      gate     <= gate_n;
      busy     <= busy_n;
      step_idx <= step_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    note_n  = note;
    gate_n  = gate;
    busy_n  = busy;
    step_n  = step_idx;
    done_n  = 1'b0;
    tload   = 1'b0;
    tval    = '0;
    go      = 1'b0;
    nxt_idx = '0;

    unique case (state)
      S_IDLE: begin
        go = start;
      end
      S_PLAY: begin
        if (tzero) begin
          state_n = S_GAP;
          gate_n  = 1'b0;
          tload   = 1'b1;
          tval    = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (tzero) begin
          if (step_idx != LAST) begin
            go      = 1'b1;
            nxt_idx = step_idx + 4'd1;
          end else if (loop_en) begin
            go      = 1'b1;
          end else begin
            state_n = S_DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            note_n  = NOTE_REST;
            step_n  = '0;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    ent = song_at(nxt_idx);
    if (go) begin
      state_n = S_PLAY;
      step_n  = nxt_idx;
      note_n  = ent.note;
      gate_n  = (ent.note != NOTE_REST);
      busy_n  = 1'b1;
      tload   = 1'b1;
      tval    = play_load(ent.dur);
    end

    // stop overrides everything, including a same-cycle start
    if (stop) begin
      state_n = S_IDLE;
      note_n  = NOTE_REST;
      gate_n  = 1'b0;
      busy_n  = 1'b0;
      step_n  = '0;
      done_n  = 1'b0;
      tload   = 1'b1;
      tval    = '0;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer with a small
// 2-tick/ms, 4 ms beat, 1 ms gap configuration.
module tb_melody_sequencer;

  localparam int TPM  = 2;
  localparam int BEAT = 4;
  localparam int GAPM = 1;
  localparam int LEN  = 8;

  logic       clk = 1'b0;
  logic       rst, start, stop, loop_en;
  logic [2:0] note;
  logic       gate, busy, done;
  logic [3:0] step_idx;

  int checks = 0;
  int errors = 0;
  int done_seen;

  int song_note [LEN] = '{1, 2, 3, 4, 5, 6, 0, 7};
  int song_dur  [LEN] = '{0, 0, 0, 0, 1, 1, 0, 3};

  melody_sequencer #(
    .TICKS_PER_MS (TPM),
    .BEAT_MS      (BEAT),
    .GAP_MS       (GAPM),
    .SONG_LEN     (LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .note     (note),
    .gate     (gate),
    .busy     (busy),
    .step_idx (step_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] note;
    logic       gate;
    logic       busy;
    logic [3:0] step;
    logic       done;
  } vec_t;

  vec_t vecs [16];

  // reference model: position in song plus elapsed cycles
  bit m_play, m_done;
  int m_step, m_el;

  function automatic int period(int s);
    return (song_dur[s] + 1) * BEAT * TPM;
  endfunction

  function automatic int play_len(int s);
    return ((song_dur[s] + 1) * BEAT - GAPM) * TPM;
  endfunction

  task automatic model_reset();
    m_play = 0; m_done = 0; m_step = 0; m_el = 0;
  endtask

  task automatic model_step(bit st, bit sp, bit lp);
    if (sp) begin
      m_play = 0; m_done = 0; m_step = 0;
    end else if (!m_play) begin
      if (m_done) m_done = 0;
      else if (st) begin
        m_play = 1; m_step = 0; m_el = 0;
      end
    end else begin
      m_el++;
      if (m_el == period(m_step)) begin
        m_el = 0;
        if (m_step < LEN - 1) m_step++;
        else if (lp) m_step = 0;
        else begin
          m_play = 0; m_done = 1; m_step = 0;
        end
      end
    end
  endtask

  function automatic logic [9:0] model_out();
    logic [2:0] n;
    logic       g;
    n = m_play ? 3'(song_note[m_step]) : 3'd0;
    g = m_play && (m_el < play_len(m_step)) && (n != 0);
    return {n, g, logic'(m_play), 4'(m_step), logic'(m_done)};
  endfunction

  function automatic logic [9:0] dut_out();
    return {note, gate, busy, step_idx, done};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    tick();
    done_seen = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; loop_en = 0;
    done_seen = 0;

    vecs[0]  = '{0,   3'd1, 1'b1, 1'b1, 4'd0, 1'b0};
    vecs[1]  = '{5,   3'd1, 1'b1, 1'b1, 4'd0, 1'b0};
    vecs[2]  = '{6,   3'd1, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[3]  = '{7,   3'd1, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[4]  = '{8,   3'd2, 1'b1, 1'b1, 4'd1, 1'b0};
    vecs[5]  = '{32,  3'd5, 1'b1, 1'b1, 4'd4, 1'b0};
    vecs[6]  = '{45,  3'd5, 1'b1, 1'b1, 4'd4, 1'b0};
    vecs[7]  = '{46,  3'd5, 1'b0, 1'b1, 4'd4, 1'b0};
    vecs[8]  = '{64,  3'd0, 1'b0, 1'b1, 4'd6, 1'b0};
    vecs[9]  = '{71,  3'd0, 1'b0, 1'b1, 4'd6, 1'b0};
    vecs[10] = '{72,  3'd7, 1'b1, 1'b1, 4'd7, 1'b0};
    vecs[11] = '{101, 3'd7, 1'b1, 1'b1, 4'd7, 1'b0};
    vecs[12] = '{102, 3'd7, 1'b0, 1'b1, 4'd7, 1'b0};
    vecs[13] = '{103, 3'd7, 1'b0, 1'b1, 4'd7, 1'b0};
    vecs[14] = '{104, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1};
    vecs[15] = '{105, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0};

    // reset state
    ticks(2);
    chk("reset_out", 32'(dut_out()), 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_out", 32'(dut_out()), 32'h0);

    // full song, table driven
    pulse_start();
    begin
      int k;
      k = 0;
      for (int c = 0; c <= 105; c++) begin
        if (k < 16 && vecs[k].cyc == c) begin
          chk($sformatf("song_c%0d", c), 32'(dut_out()),
              32'({vecs[k].note, vecs[k].gate, vecs[k].busy,
                   vecs[k].step, vecs[k].done}));
          k++;
        end
        if (c < 105) tick();
      end
    end
    chk("song_done_once", done_seen, 1);

    // loop
    do_reset();
    loop_en = 1'b1;
    pulse_start();
    ticks(104);
    chk("loop_wrap", 32'(dut_out()),
        32'({3'd1, 1'b1, 1'b1, 4'd0, 1'b0}));
    ticks(20);
    loop_en = 1'b0;
    chk("loop_no_done", done_seen, 0);

    // stop mid step 2
    do_reset();
    pulse_start();
    ticks(18);
    chk("pre_stop_step", step_idx, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_out", 32'(dut_out()), 32'h0);
    ticks(120);
    chk("stop_idle", 32'(dut_out()), 32'h0);
    chk("stop_no_done", done_seen, 0);

    // start and stop together
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop", 32'(dut_out()), 32'h0);
    tick();
    chk("start_stop_hold", busy, 0);

    // start while busy
    do_reset();
    pulse_start();
    ticks(26);
    pulse_start();
    ticks(4);
    chk("rebusy_gap", 32'(dut_out()),
        32'({3'd4, 1'b0, 1'b1, 4'd3, 1'b0}));
    tick();
    chk("rebusy_step4", 32'(dut_out()),
        32'({3'd5, 1'b1, 1'b1, 4'd4, 1'b0}));

    // async reset between edges
    do_reset();
    pulse_start();
    ticks(3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_gate", gate, 0);
    chk("async_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    ticks(20);
    chk("async_idle", 32'(dut_out()), 32'h0);
    pulse_start();
    chk("async_restart", 32'(dut_out()),
        32'({3'd1, 1'b1, 1'b1, 4'd0, 1'b0}));

    // randomized against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 63) == 0) loop_en = ~loop_en;
      tick();
      model_step(start, stop, loop_en);
      chk("rand", 32'(dut_out()), 32'(model_out()));
    end
    start = 0; stop = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Upstream stage of the tone generators. It steps through a fixed song table and, for each step, drives a 3-bit note code and a gate line. The note code selects which tone generator sounds; the gate drives that generator's switch input. Every note is followed by a short silent articulation gap. Start, stop and loop controls come from the board buttons and switches.

Parameters:
TICKS_PER_MS, 20000, clk cycles per millisecond (20 MHz system clock).
BEAT_MS, 250, length of one beat in ms.
GAP_MS, 20, silent gap at the end of every step in ms. Legal range: 1 <= GAP_MS < BEAT_MS.
SONG_LEN, 8, number of entries in the song table (max 16).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request to play from step 0.
stop  input  1  abort playback; level or pulse.
loop_en  input  1  sampled at end of last step; 1 = restart at step 0.
note  output  3  note code: 0 = rest, 1..7 = C,D,E,F,G,A,B.
gate  output  1  1 = tone enabled; feeds the tone generator's switch input.
busy  output  1  high in PLAY and GAP.
step_idx  output  4  current song step.
done  output  1  one-cycle pulse when the song ends without looping.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE; note=0, gate=0, busy=0, step_idx=0, done=0; timer=0.
- States: IDLE, PLAY, GAP, DONE. All outputs are registered.
- IDLE:
  - start=1 and stop=0 -> next cycle enter PLAY with step_idx=0 and busy=1.
  - In that cycle note=table[0].note, and gate=1 when the note code is non-zero.
  - The timer loads P-1.
- PLAY:
  - Lasts exactly P = ((dur+1)*BEAT_MS - GAP_MS)*TICKS_PER_MS cycles. dur is the 2-bit table field, so 1..4 beats.
  - On timer==0 -> GAP; gate=0, note holds, timer loads G-1.
  - G = GAP_MS*TICKS_PER_MS.
- GAP:
  - Lasts exactly G cycles.
  - On timer==0 with step_idx < SONG_LEN-1 -> PLAY with the next step: step_idx+1, note and gate from the table.
  - At the last step with loop_en=1 -> PLAY at step 0, with no extra cycles.
  - At the last step with loop_en=0 -> DONE.
- DONE: one cycle. done=1, busy=0, gate=0, note=0, step_idx=0. Then IDLE.
- Rest steps (note code 0): run the full PLAY and GAP timing with gate=0 and note=0.
- stop:
  - In any state, the next cycle is IDLE with gate=0, note=0, busy=0 and step_idx=0.
  - No done pulse is produced.
  - stop wins over a simultaneous start.
- start while busy: ignored; playback is not restarted.
- start in DONE: ignored.
- Timer:
  - Loadable down-counter of width $clog2(4*BEAT_MS*TICKS_PER_MS).
  - With default parameters that is 25 bits.
  - No wrap-around is allowed; the timer only ever counts down from a load value.
- Mid-operation reset: asynchronous return to reset values in the same instant.
- Step timing: each step period is exactly (dur+1)*BEAT_MS*TICKS_PER_MS cycles, measured from the first PLAY cycle to the next first PLAY cycle.

Decomposition:
- Shared package (music_pkg) holds:
  - Note code constants (NOTE_REST=0 .. NOTE_B=7).
  - The state enum.
  - The song table: SONG_LEN entries of {note[2:0], dur[1:0]}.
  - Default song: (C,0) (D,0) (E,0) (F,0) (G,1) (A,1) (REST,0) (B,3), i.e. 13 beats total.
- One sub-module, seq_timer: a loadable down-counter with inputs load and load_val, and a zero flag.
- The FSM and table lookup stay in melody_sequencer.

Test Plan:
All scenarios use TICKS_PER_MS=2, BEAT_MS=4, GAP_MS=1. This gives 6 PLAY + 2 GAP cycles per beat.
1. Basic start:
   - Stimulus: after rst release, pulse start.
   - Response: next cycle busy=1, note=1, gate=1; gate stays high 6 cycles, then low 2; step_idx=1, note=2 on cycle 9.
2. Full song:
   - Stimulus: start with loop_en=0.
   - Response: step 4 (G) gate high 14 cycles; step 6 (rest) gate=0 for 8 cycles; done pulses once exactly 104 cycles after the first PLAY cycle, then busy=0.
3. Loop:
   - Stimulus: loop_en=1 through the end of step 7.
   - Response: the cycle after step 7's GAP shows step_idx=0, note=1, gate=1; no done pulse.
4. Stop:
   - Stimulus: assert stop in the middle of step 2's PLAY.
   - Response: next cycle gate=0, note=0, busy=0, step_idx=0; no done pulse.
   - Stimulus: start and stop asserted together in IDLE.
   - Response: stays IDLE.
5. Start while busy:
   - Stimulus: re-pulse start during step 3.
   - Response: step_idx and timing are unaffected.
6. Async reset:
   - Stimulus: assert rst between clock edges during PLAY.
   - Response: gate=0 and busy=0 before the next clk edge; after release, idle until start.
